// File: rtl/tbuf_miss_sched.sv
// Translation-miss scheduler: filters duplicate misses, queues unique ones,
// allocates them into the miss-tracking CAM and hands each to the page walker.
module tbuf_miss_sched #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             except,
  input  logic             except_thread,
  input  logic             req0_en,
  input  logic [WIDTH-1:0] req0_addr,
  input  logic             req0_thread,
  input  logic             req1_en,
  input  logic [WIDTH-1:0] req1_addr,
  input  logic             req1_thread,
  output logic             stall,
  output logic [WIDTH-1:0] chk_addr0,
  output logic [WIDTH-1:0] chk_addr1,
  input  logic             chk_match0,
  input  logic             chk_match1,
  input  logic             cam_free,
  output logic [WIDTH-1:0] new_addr,
  output logic             new_thread,
  output logic             new_en,
  output logic             walk_valid,
  output logic [WIDTH-1:0] walk_addr,
  output logic             walk_thread,
  input  logic             walk_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {IDLE, SEND} state_t;
  state_t state;

  logic [DEPTH-1:0] q_valid;
  logic [DEPTH-1:0] q_thread;
  logic [WIDTH-1:0] q_addr [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    tail1;
  logic [CW-1:0]    count;

  logic hit0;
  logic hit1;
  logic keep0;
  logic keep1;
  logic head_valid;
  logic alloc;
  logic pop;

  assign chk_addr0 = req0_addr;
  assign chk_addr1 = req1_addr;
  assign stall     = (count > CW'(DEPTH - 2));

  // Queue hit: any still-valid entry (including a head being allocated) blocks a duplicate.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && (q_thread[i] == req0_thread) && (q_addr[i] == req0_addr)) hit0 = 1'b1;
      if (q_valid[i] && (q_thread[i] == req1_thread) && (q_addr[i] == req1_addr)) hit1 = 1'b1;
    end
  end

  assign keep0 = req0_en & ~chk_match0 & ~hit0 & ~stall
               & ~(except & (except_thread == req0_thread));
  assign keep1 = req1_en & ~chk_match1 & ~hit1 & ~stall
               & ~(except & (except_thread == req1_thread))
               & ~(keep0 & (req1_thread == req0_thread) & (req1_addr == req0_addr));

  assign head_valid = q_valid[head];
  assign alloc      = (state == IDLE) & head_valid & cam_free
                    & ~(except & (except_thread == q_thread[head]));
  // Flushed entries stay counted until they reach the head and are discarded here.
  assign pop        = alloc | ((count != '0) & ~head_valid);
  assign tail1      = tail + PW'(1);

  assign new_en     = alloc;
  assign new_addr   = q_addr[head];
  assign new_thread = (count != '0) & q_thread[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid  <= '0;
      q_thread <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) q_addr[i] <= '0;
    end else begin
      if (except) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_thread[i] == except_thread) q_valid[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (keep0) begin
        q_valid[tail]  <= 1'b1;
        q_thread[tail] <= req0_thread;
        q_addr[tail]   <= req0_addr;
      end
      if (keep1) begin
        q_valid[keep0 ? tail1 : tail]  <= 1'b1;
        q_thread[keep0 ? tail1 : tail] <= req1_thread;
        q_addr[keep0 ? tail1 : tail]   <= req1_addr;
      end
      tail  <= tail + PW'(keep0) + PW'(keep1);
      count <= count + CW'(keep0) + CW'(keep1) - CW'(pop);
    end
  end

  // Walk handshake: walk_valid stays high with addr/thread stable until walk_ready
  // is sampled high at a rising edge, unless a flush of walk_thread cancels it first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      walk_valid  <= 1'b0;
      walk_addr   <= '0;
      walk_thread <= 1'b0;
    end else if (state == IDLE) begin
      if (alloc) begin
        state       <= SEND;
        walk_valid  <= 1'b1;
        walk_addr   <= q_addr[head];
        walk_thread <= q_thread[head];
      end
    end else begin
      if ((except && (except_thread == walk_thread)) || walk_ready) begin
        state      <= IDLE;
        walk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tbuf_miss_sched.sv
// Directed bench for tbuf_miss_sched: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.
module tb_tbuf_miss_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        except;
  logic        except_thread;
  logic        req0_en;
  logic [10:0] req0_addr;
  logic        req0_thread;
  logic        req1_en;
  logic [10:0] req1_addr;
  logic        req1_thread;
  logic        stall;
  logic [10:0] chk_addr0;
  logic [10:0] chk_addr1;
  logic        chk_match0;
  logic        chk_match1;
  logic        cam_free;
  logic [10:0] new_addr;
  logic        new_thread;
  logic        new_en;
  logic        walk_valid;
  logic [10:0] walk_addr;
  logic        walk_thread;
  logic        walk_ready;

  int tests = 0;
  int fails = 0;

  tbuf_miss_sched #(.WIDTH(11), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
    .req0_en(req0_en), .req0_addr(req0_addr), .req0_thread(req0_thread),
    .req1_en(req1_en), .req1_addr(req1_addr), .req1_thread(req1_thread),
    .stall(stall), .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .chk_match0(chk_match0), .chk_match1(chk_match1), .cam_free(cam_free),
    .new_addr(new_addr), .new_thread(new_thread), .new_en(new_en),
    .walk_valid(walk_valid), .walk_addr(walk_addr), .walk_thread(walk_thread),
    .walk_ready(walk_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_req();
    req0_en = 1'b0; req1_en = 1'b0;
    chk_match0 = 1'b0; chk_match1 = 1'b0;
    except = 1'b0;
  endtask

  task automatic drive0(input logic [10:0] a, input logic t);
    req0_en = 1'b1; req0_addr = a; req0_thread = t;
  endtask

  task automatic drive1(input logic [10:0] a, input logic t);
    req1_en = 1'b1; req1_addr = a; req1_thread = t;
  endtask

  // Waits (bounded) for walk_valid, checks the offered walk, then lets it transfer.
  task automatic expect_walk(input string tag, input logic [10:0] a, input logic t);
    int n = 0;
    while (!walk_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, walk_valid, 1);
    chk({tag, "_addr"}, walk_addr, a);
    chk({tag, "_thr"}, walk_thread, t);
    tick();
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      settle();
      chk({tag, "_new_en"}, new_en, 0);
      chk({tag, "_walk_valid"}, walk_valid, 0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; except = 1'b0; except_thread = 1'b0;
    req0_en = 1'b0; req0_addr = '0; req0_thread = 1'b0;
    req1_en = 1'b0; req1_addr = '0; req1_thread = 1'b0;
    chk_match0 = 1'b0; chk_match1 = 1'b0; cam_free = 1'b1; walk_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_walk_valid", walk_valid, 0);
    chk("rst_walk_addr", walk_addr, 0);
    chk("rst_stall", stall, 0);
    chk("rst_new_en", new_en, 0);
    chk("rst_new_thread", new_thread, 0);

    // Single miss; a same-address request during allocation must be dropped.
    drive0(11'h155, 1'b0);
    settle();
    chk("t1_chk_addr0", chk_addr0, 11'h155);
    chk("t1_new_en_n", new_en, 0);
    tick();
    clr_req();
    drive0(11'h155, 1'b0);
    settle();
    chk("t1_new_en", new_en, 1);
    chk("t1_new_addr", new_addr, 11'h155);
    chk("t1_new_thread", new_thread, 0);
    tick();
    clr_req();
    chk("t1_walk_valid", walk_valid, 1);
    chk("t1_walk_addr", walk_addr, 11'h155);
    chk("t1_walk_thr", walk_thread, 0);
    chk("t1_send_new_en", new_en, 0);
    tick();
    chk("t1_walk_hold", walk_valid, 1);
    walk_ready = 1'b1;
    tick();
    walk_ready = 1'b0;
    chk("t1_walk_done", walk_valid, 0);
    expect_quiet("t1_quiet", 3);

    // Duplicate filtering: same pair, queue hit, CAM hit, then one new address.
    cam_free = 1'b0;
    drive0(11'h020, 1'b1); drive1(11'h020, 1'b1);
    tick();
    clr_req();
    settle();
    chk("t2_head_addr", new_addr, 11'h020);
    chk("t2_head_thr", new_thread, 1);
    drive0(11'h020, 1'b1);
    tick();
    clr_req();
    drive0(11'h030, 1'b1); chk_match0 = 1'b1;
    tick();
    clr_req();
    drive0(11'h040, 1'b1);
    tick();
    clr_req();
    settle();
    chk("t2_stall", stall, 0);
    cam_free = 1'b1; walk_ready = 1'b1;
    expect_walk("t2_w0", 11'h020, 1'b1);
    expect_walk("t2_w1", 11'h040, 1'b1);
    walk_ready = 1'b0;
    expect_quiet("t2_quiet", 3);

    // CAM full holds the head until cam_free rises.
    cam_free = 1'b0;
    drive0(11'h100, 1'b0);
    tick();
    clr_req();
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t3_blocked", new_en, 0);
      tick();
    end
    cam_free = 1'b1;
    settle();
    chk("t3_new_en", new_en, 1);
    chk("t3_new_addr", new_addr, 11'h100);
    walk_ready = 1'b1;
    expect_walk("t3_w", 11'h100, 1'b0);
    walk_ready = 1'b0;

    // Fill to DEPTH, check stall and dropped request, drain in order; three rounds.
    for (int r = 0; r < 3; r++) begin
      logic [10:0] base;
      base = 11'h200 + 11'(r * 16);
      cam_free = 1'b0; walk_ready = 1'b0;
      drive0(base, 1'b0); drive1(base + 11'd1, 1'b1);
      settle();
      chk("t4_stall_0", stall, 0);
      tick();
      drive0(base + 11'd2, 1'b0); drive1(base + 11'd3, 1'b1);
      settle();
      chk("t4_stall_2", stall, 0);
      tick();
      clr_req();
      settle();
      chk("t4_stall_full", stall, 1);
      drive0(base + 11'd4, 1'b0);
      tick();
      clr_req();
      cam_free = 1'b1; walk_ready = 1'b1;
      for (int k = 0; k < 4; k++) expect_walk("t4_w", base + 11'(k), 1'(k));
      walk_ready = 1'b0;
      expect_quiet("t4_quiet", 3);
    end

    // Flush thread 0 with {A t0, B t1, C t0} queued: only B is walked.
    cam_free = 1'b0; walk_ready = 1'b0;
    drive0(11'h0A0, 1'b0); drive1(11'h0B0, 1'b1);
    tick();
    clr_req();
    drive0(11'h0C0, 1'b0);
    tick();
    clr_req();
    settle();
    chk("t5_stall3", stall, 1);
    except = 1'b1; except_thread = 1'b0;
    tick();
    except = 1'b0;
    settle();
    chk("t5_stall_after_flush", stall, 1);
    cam_free = 1'b1; walk_ready = 1'b1;
    expect_walk("t5_wB", 11'h0B0, 1'b1);
    walk_ready = 1'b0;
    expect_quiet("t5_quiet", 4);
    chk("t5_stall_empty", stall, 0);
    chk("t5_new_thread_empty", new_thread, 0);

    // Flush during SEND: other thread keeps the walk, own thread cancels it.
    drive0(11'h0D0, 1'b1);
    tick();
    clr_req();
    tick();
    chk("t5_send_valid", walk_valid, 1);
    chk("t5_send_thr", walk_thread, 1);
    except = 1'b1; except_thread = 1'b0;
    tick();
    except = 1'b0;
    chk("t5_other_flush", walk_valid, 1);
    except = 1'b1; except_thread = 1'b1; walk_ready = 1'b1;
    tick();
    clr_req();
    walk_ready = 1'b0;
    chk("t5_cancel", walk_valid, 0);
    expect_quiet("t5_cancel_quiet", 3);

    // Requests of the excepting thread are dropped on entry.
    cam_free = 1'b0;
    except = 1'b1; except_thread = 1'b1;
    drive0(11'h077, 1'b1); drive1(11'h078, 1'b0);
    tick();
    clr_req();
    settle();
    chk("t5_drop_addr", new_addr, 11'h078);
    chk("t5_drop_thr", new_thread, 0);
    cam_free = 1'b1; walk_ready = 1'b1;
    expect_walk("t5_keep", 11'h078, 1'b0);
    walk_ready = 1'b0;
    expect_quiet("t5_drop_quiet", 3);

    // Reset while SEND holds a walk and three entries are queued.
    cam_free = 1'b0;
    drive0(11'h300, 1'b0); drive1(11'h301, 1'b0);
    tick();
    drive0(11'h302, 1'b0); drive1(11'h303, 1'b0);
    tick();
    clr_req();
    cam_free = 1'b1;
    tick();
    chk("t6_pre_valid", walk_valid, 1);
    chk("t6_pre_stall", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t6_walk_valid", walk_valid, 0);
    chk("t6_walk_addr", walk_addr, 0);
    chk("t6_stall", stall, 0);
    walk_ready = 1'b1;
    expect_quiet("t6_quiet", 4);
    drive0(11'h3F0, 1'b1);
    tick();
    clr_req();
    settle();
    chk("t6_new_en", new_en, 1);
    chk("t6_new_addr", new_addr, 11'h3F0);
    chk("t6_new_thread", new_thread, 1);
    expect_walk("t6_w", 11'h3F0, 1'b1);
    walk_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
